// File: rtl/control_pkg.sv
// Shared definitions for the multicycle main control unit: state encoding,
// opcode values, ALU operation codes and the decoded control vector.
package control_pkg;

  // FSM states; FETCH must encode as 0 so reset shows state=0 on the debug port.
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11
  } state_t;

  // Instruction opcodes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // ALU operation codes; alu_control decodes the function field on RTYPE
  // and passes every other value straight to the ALU.
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;
  localparam logic [2:0] ALUOP_ADD   = 3'b101;
  localparam logic [2:0] ALUOP_SUB   = 3'b110;
  localparam logic [2:0] ALUOP_AND   = 3'b000;
  localparam logic [2:0] ALUOP_OR    = 3'b001;

  // B-operand and PC source selects.
  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_SHIMM = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Raw per-state control vector. pc_write / ir_write in FETCH are the
  // unqualified requests; the top gates them with the memory handshake.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  // True for every opcode the control unit knows how to sequence.
  function automatic logic is_known_opcode(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI: is_known_opcode = 1'b1;
      default:                  is_known_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_output_decode.sv
// Moore output decode: maps the current state (and the opcode where an
// output depends on it) to the raw datapath control vector.
module control_output_decode
  import control_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  // Every field defaults to 0 / ALU add, then each state sets what it uses.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALUOP_ADD;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      DECODE: begin
        ctrl.alu_src_b  = SRC_B_SHIMM;
        ctrl.illegal_op = ~is_known_opcode(opcode);
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_ANDI: ctrl.alu_op = ALUOP_AND;
          OP_ORI:  ctrl.alu_op = ALUOP_OR;
          default: ctrl.alu_op = ALUOP_ADD;
        endcase
      end
      I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      default: begin
        ctrl.alu_op = ALUOP_ADD;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main control unit: state register, next-state sequencing,
// PC enable gating and reset forcing around the combinational output decode.
//
// Memory handshake: the FSM holds its memory enable (mem_read or mem_write)
// in FETCH, MEM_READ and MEM_WRITE and the access completes in the first
// cycle where mem_ready=1; the FSM then leaves the state on that clock edge.
// mem_ready has no effect in any other state.
module multicycle_control
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] ALUop,
  output logic       pc_en,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   fetch_ok;
  logic   pc_write;

  control_output_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  // State register; reset returns to FETCH without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state sequencing; waits in memory states until mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:             state_d = MEM_ADDR;
          OP_RTYPE:                 state_d = R_EXEC;
          OP_BEQ:                   state_d = BRANCH;
          OP_J:                     state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = I_EXEC;
          default:                  state_d = FETCH;
        endcase
      end
      MEM_ADDR:  state_d = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  state_d = mem_ready ? MEM_WB : MEM_READ;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: state_d = mem_ready ? FETCH : MEM_WRITE;
      R_EXEC:    state_d = R_WB;
      R_WB:      state_d = FETCH;
      BRANCH:    state_d = FETCH;
      JUMP:      state_d = FETCH;
      I_EXEC:    state_d = I_WB;
      I_WB:      state_d = FETCH;
      default:   state_d = FETCH;
    endcase
  end

  // The fetch-time PC and IR writes only take effect on the cycle the
  // instruction word actually arrives; the jump PC write is unconditional.
  assign fetch_ok = (state_q != FETCH) | mem_ready;
  assign pc_write = ctrl.pc_write & fetch_ok;

  // Enables are forced low while reset is held so an aborted instruction
  // cannot write anything; selects simply show their FETCH values.
  assign pc_en      = ~reset & (pc_write | (ctrl.pc_write_cond & zero));
  assign ir_write   = ~reset & ctrl.ir_write & mem_ready;
  assign mem_read   = ~reset & ctrl.mem_read;
  assign mem_write  = ~reset & ctrl.mem_write;
  assign reg_write  = ~reset & ctrl.reg_write;
  assign illegal_op = ~reset & ctrl.illegal_op;

  // Retirement: leaving an execute/writeback/memory state for FETCH.
  // DECODE is excluded so an illegal opcode never counts as retired.
  assign instr_done = ~reset & (state_d == FETCH) &
                      (state_q != FETCH) & (state_q != DECODE);

  assign ALUop      = ctrl.alu_op;
  assign iord       = ctrl.iord;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign pc_source  = ctrl.pc_source;
  assign state      = state_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle main control unit: a Moore-style FSM that sequences each instruction through fetch, decode, execute, memory and writeback and drives the datapath enables and mux selects. It is the producer of the 3-bit `ALUop` consumed by `alu_control`. When `ALUop` is 3'b111, `alu_control` decodes the function field; any other `ALUop` value is passed through to the ALU as the operation code.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  instruction opcode from the instruction register; stable after DECODE.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory handshake; the access completes in a cycle where it is 1.
- `ALUop`  out  3  ALU operation: 111 = R-type, 101 = add, 110 = sub, 000 = and, 001 = or.
- `pc_en`  out  1  PC load enable.
- `ir_write`, `mem_read`, `mem_write`, `reg_write`  out  1 each  datapath enables.
- `iord`, `reg_dst`, `mem_to_reg`, `alu_src_a`  out  1 each  mux selects.
- `alu_src_b`  out  2  B-operand select: 00 = reg, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `pc_source`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done`  out  1  one-cycle pulse when an instruction retires.
- `illegal_op`  out  1  high in DECODE when the opcode is unrecognized.
- `state`  out  4  current state, for debug.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101.
- `pc_en` = `pc_write` | (`pc_write_cond` & `zero`). Both terms are internal.
- Unlisted outputs are 0. Unlisted `ALUop` is 101.
- States and the outputs each one asserts:
  - FETCH: `mem_read`=1, `iord`=0, `alu_src_b`=01, `ALUop`=101, `pc_source`=00; `ir_write` and `pc_write` equal `mem_ready`. Stays in FETCH until `mem_ready`=1, then goes to DECODE.
  - DECODE: `alu_src_b`=11, `ALUop`=101. Next state by opcode: lw/sw→MEM_ADDR, R→R_EXEC, beq→BRANCH, j→JUMP, addi/andi/ori→I_EXEC. Any other opcode→FETCH with `illegal_op`=1.
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `ALUop`=101. Goes to MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ: `mem_read`=1, `iord`=1. Waits for `mem_ready`, then goes to MEM_WB.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Goes to FETCH.
  - MEM_WRITE: `mem_write`=1, `iord`=1. Waits for `mem_ready`, then goes to FETCH.
  - R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `ALUop`=111. Goes to R_WB.
  - R_WB: `reg_write`=1, `reg_dst`=1. Goes to FETCH.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `ALUop`=110, `pc_write_cond`=1, `pc_source`=01. Goes to FETCH.
  - JUMP: `pc_write`=1, `pc_source`=10. Goes to FETCH.
  - I_EXEC: `alu_src_a`=1, `alu_src_b`=10. `ALUop` is 101 for addi, 000 for andi, 001 for ori. Goes to I_WB.
  - I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Goes to FETCH.
- `instr_done` = (next state is FETCH) & (state is not FETCH) & (state is not DECODE). An illegal opcode does not retire.

## Timing
- The state register updates on the `clk` rising edge. All outputs are combinational from the state, plus `mem_ready`, `zero` and `opcode` where listed.
- Reset behaviour:
  - `reset`=1 forces state to FETCH asynchronously.
  - While `reset` is high, `pc_en`, `ir_write`, `mem_read`, `mem_write`, `reg_write`, `instr_done` and `illegal_op` are forced to 0.
  - Other outputs take their FETCH values: `ALUop`=101, `alu_src_b`=01, `state`=0.
  - A reset mid-instruction aborts the instruction with no further writes.
- Cycle counts with `mem_ready` tied to 1: R/addi/andi/ori 4, lw 5, sw 4, beq 3, j 3.
- Each cycle with `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. The memory enables stay asserted while waiting.
- `mem_ready` is ignored in all other states.
- `opcode` is sampled in DECODE, MEM_ADDR and I_EXEC. It must not change between DECODE and retirement.

## Structure
- Package `control_pkg` holds:
  - the state enum (4 bits, FETCH = 0);
  - opcode localparams;
  - `ALUop` localparams (`ALUOP_RTYPE`, `ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_AND`, `ALUOP_OR`), shared with `alu_control`.
- Sub-module `control_output_decode` is purely combinational: state + opcode → control vector. The top level holds the state register, the next-state logic, `pc_en` gating and reset forcing.

## Test plan
- Reset asserted mid-MEM_WRITE → `mem_write` drops immediately; state=FETCH; no `instr_done`.
- R-type, `mem_ready`=1 → FETCH, DECODE, R_EXEC (`ALUop`=111), R_WB (`reg_write`=1, `reg_dst`=1, `instr_done`=1). Four cycles.
- lw with `mem_ready` low for 2 cycles in MEM_READ → 7 cycles total; `mem_to_reg`=1 in MEM_WB.
- beq with `zero`=1 → `pc_en`=1 and `pc_source`=01 in BRANCH. With `zero`=0 → `pc_en`=0. Retires in 3 cycles.
- andi → `ALUop`=000 in I_EXEC. ori → 001. addi → 101.
- opcode 111111 → `illegal_op`=1 for one cycle in DECODE; returns to FETCH; `instr_done` stays 0.
